// File: rtl/module_bcd_conv_arbiter.sv
// module_bcd_conv_arbiter
//   Shares one external binary-to-BCD converter between N_REQ requesters.
//   A round-robin arbiter grants one requester at a time. The winner's operand
//   is latched onto conv_bin and held for CONV_LAT cycles. The converter result
//   is then captured and returned on a single valid/ready response channel,
//   tagged with the requester index.
//
// Parameters
//   N_REQ     number of requesters (2..4)
//   CONV_LAT  cycles from conv_bin stable to conv_bcd valid (1..4)
//   MAX_BIN   largest operand the converter maps (range check only)
//
// Optional feature
//   BCD_RANGE_CHK_EN  when defined, an operand above MAX_BIN bypasses the
//                     converter. It answers at once with rsp_bcd=8'h00 and
//                     rsp_err=1. When undefined, rsp_err is tied to 0.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester request
//   req_bin      packed operands, requester i on [8i+7:8i]
//   req_ready    one-hot grant, asserted only while idle
//   rsp_valid    response available
//   rsp_ready    response accepted by the consumer
//   rsp_bcd      packed BCD result {tens,units}
//   rsp_id       index of the requester served
//   rsp_err      operand out of range
//   conv_bin     operand driven to the converter
//   conv_bcd     converter result
//   busy         high whenever the FSM is not idle
module module_bcd_conv_arbiter #(
  parameter int N_REQ    = 2,
  parameter int CONV_LAT = 1,
  parameter int MAX_BIN  = 81
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_bin,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_bcd,
  output logic [1:0]         rsp_id,
  output logic               rsp_err,
  output logic [7:0]         conv_bin,
  input  logic [7:0]         conv_bcd,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Reject unsupported configurations at elaboration time.
  if (N_REQ < 2 || N_REQ > 4 || CONV_LAT < 1 || CONV_LAT > 4 ||
      MAX_BIN < 0 || MAX_BIN > 255) begin : g_param_check
    $error("module_bcd_conv_arbiter: parameter out of range");
  end

`ifdef BCD_RANGE_CHK_EN
  localparam logic [7:0] MAX_BIN_C = MAX_BIN[7:0];
`endif

  state_t           state_r;
  logic [1:0]       rr_ptr_r;
  logic [1:0]       cnt_r;
  logic [7:0]       conv_bin_r;
  logic [7:0]       rsp_bcd_r;
  logic [1:0]       rsp_id_r;
  logic             rsp_valid_r;
  logic             busy_r;
`ifdef BCD_RANGE_CHK_EN
  logic             rsp_err_r;
`endif

  logic             found_s;
  logic [1:0]       grant_id_s;
  logic [N_REQ-1:0] grant_s;
  logic [7:0]       sel_bin_s;
  logic [2:0]       cand_s;
  logic             hit_s;

  // Round-robin search from rr_ptr+1 upward with wrap; first valid requester wins.
  always_comb begin
    found_s    = 1'b0;
    grant_id_s = 2'd0;
    grant_s    = '0;
    sel_bin_s  = 8'd0;
    cand_s     = 3'd0;
    hit_s      = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = 3'((int'(rr_ptr_r) + k) % N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        hit_s      = !found_s && (cand_s == 3'(j)) && req_valid[j];
        found_s    = found_s | hit_s;
        grant_id_s = hit_s ? 2'(j) : grant_id_s;
        grant_s[j] = grant_s[j] | hit_s;
        sel_bin_s  = hit_s ? req_bin[8*j +: 8] : sel_bin_s;
      end
    end
  end

  // The grant is combinational. It is forced low while reset is asserted
  // so that every output reads 0 during reset, even with requests pending.
  assign req_ready = (rst_n && (state_r == IDLE)) ? grant_s : '0;

  // Control FSM together with every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 2'(N_REQ - 1);
      cnt_r       <= 2'd0;
      conv_bin_r  <= 8'd0;
      rsp_bcd_r   <= 8'd0;
      rsp_id_r    <= 2'd0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef BCD_RANGE_CHK_EN
      rsp_err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            rr_ptr_r <= grant_id_s;
            rsp_id_r <= grant_id_s;
            busy_r   <= 1'b1;
            cnt_r    <= 2'd0;
`ifdef BCD_RANGE_CHK_EN
            // Out-of-range operands never reach the converter, and conv_bin keeps its old value.
            if (sel_bin_s > MAX_BIN_C) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_bcd_r   <= 8'h00;
              rsp_err_r   <= 1'b1;
            end else begin
              state_r     <= WAIT;
              conv_bin_r  <= sel_bin_s;
              rsp_err_r   <= 1'b0;
            end
`else
            state_r    <= WAIT;
            conv_bin_r <= sel_bin_s;
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        WAIT: begin
          // conv_bin stays put; sample the converter on the last latency cycle.
          if (cnt_r == 2'(CONV_LAT - 1)) begin
            rsp_bcd_r   <= conv_bcd;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign conv_bin  = conv_bin_r;
  assign rsp_bcd   = rsp_bcd_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_valid = rsp_valid_r;
  assign busy      = busy_r;
`ifdef BCD_RANGE_CHK_EN
  assign rsp_err   = rsp_err_r;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_module_bcd_conv_arbiter.sv
// Testbench for module_bcd_conv_arbiter.
//   Instance dut uses CONV_LAT=1 and a combinational converter model.
//   Instance dut_l3 uses CONV_LAT=3 and a two-stage converter pipeline.
module tb_module_bcd_conv_arbiter;

`ifdef BCD_RANGE_CHK_EN
  localparam bit RE = 1'b1;
`else
  localparam bit RE = 1'b0;
`endif
  localparam int IN_LAT  = 2;
  localparam int OOR_LAT = RE ? 1 : 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_bin;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [7:0]  rsp_bcd, conv_bin, conv_bcd;
  logic [1:0]  rsp_id;

  logic [1:0]  req_valid_b, req_ready_b;
  logic [15:0] req_bin_b;
  logic        rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
  logic [7:0]  rsp_bcd_b, conv_bin_b, conv_bcd_b;
  logic [1:0]  rsp_id_b;
  logic [7:0]  pipe1_b = 8'h00, pipe2_b = 8'h00;

  int          errors = 0;
  int          checks = 0;
  logic [10:0] exp_q[$];
  int          grant_log[$];

  typedef struct {
    logic [1:0] valid;
    logic [7:0] bin0;
    logic [7:0] bin1;
    logic [1:0] exp_ready;
    logic [7:0] exp_bcd;
    logic [1:0] exp_id;
    logic       exp_err;
    int         exp_lat;
    logic [7:0] exp_conv;
  } vec_t;
  vec_t vecs[9];

  // Converter reference model: 0..81 maps to packed BCD, anything larger gives 8'h00.
  function automatic logic [7:0] to_bcd(input logic [7:0] b);
    logic [7:0] t;
    logic [7:0] u;
    if (b > 8'd81) return 8'h00;
    t = b / 8'd10;
    u = b % 8'd10;
    return {t[3:0], u[3:0]};
  endfunction

  assign conv_bcd   = to_bcd(conv_bin);
  assign conv_bcd_b = pipe2_b;
  always @(posedge clk) begin
    pipe1_b <= to_bcd(conv_bin_b);
    pipe2_b <= pipe1_b;
  end

  always #5 clk = ~clk;

  module_bcd_conv_arbiter #(.N_REQ(2), .CONV_LAT(1), .MAX_BIN(81)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bcd(rsp_bcd), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .conv_bin(conv_bin), .conv_bcd(conv_bcd), .busy(busy));

  module_bcd_conv_arbiter #(.N_REQ(2), .CONV_LAT(3), .MAX_BIN(81)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_bin(req_bin_b),
    .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_bcd(rsp_bcd_b), .rsp_id(rsp_id_b), .rsp_err(rsp_err_b),
    .conv_bin(conv_bin_b), .conv_bcd(conv_bcd_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sample at the falling edge: push on request handshake, pop and compare on response handshake.
  task automatic sample();
    logic [10:0] e;
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({to_bcd(req_bin[8*i +: 8]), 2'(i), RE && (req_bin[8*i +: 8] > 8'd81)});
          grant_log.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: actual=%0h required=none", {rsp_bcd, rsp_id, rsp_err});
        end else begin
          e = exp_q.pop_front();
          chk("sb_rsp", 32'({rsp_bcd, rsp_id, rsp_err}), 32'(e));
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      sample();
      adv();
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int lat;

    vecs[0] = '{2'b01, 8'd45,  8'd7,   2'b01, 8'h45, 2'd0, 1'b0, IN_LAT,  8'd45};
    vecs[1] = '{2'b11, 8'd10,  8'd81,  2'b10, 8'h81, 2'd1, 1'b0, IN_LAT,  8'd81};
    vecs[2] = '{2'b11, 8'd10,  8'd81,  2'b01, 8'h10, 2'd0, 1'b0, IN_LAT,  8'd10};
    vecs[3] = '{2'b10, 8'd33,  8'd0,   2'b10, 8'h00, 2'd1, 1'b0, IN_LAT,  8'd0};
    vecs[4] = '{2'b10, 8'd33,  8'd9,   2'b10, 8'h09, 2'd1, 1'b0, IN_LAT,  8'd9};
    vecs[5] = '{2'b01, 8'd80,  8'd12,  2'b01, 8'h80, 2'd0, 1'b0, IN_LAT,  8'd80};
    vecs[6] = '{2'b01, 8'd82,  8'd12,  2'b01, 8'h00, 2'd0, RE,   OOR_LAT, RE ? 8'd80 : 8'd82};
    vecs[7] = '{2'b10, 8'd1,   8'd255, 2'b10, 8'h00, 2'd1, RE,   OOR_LAT, RE ? 8'd80 : 8'd255};
    vecs[8] = '{2'b11, 8'd63,  8'd27,  2'b01, 8'h63, 2'd0, 1'b0, IN_LAT,  8'd63};

    req_valid = 2'b00; req_bin = 16'd0; rsp_ready = 1'b1;
    req_valid_b = 2'b00; req_bin_b = 16'd0; rsp_ready_b = 1'b1;

    // Reset: every output is 0 even while requests are pending.
    #1;
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_valid_b = 2'b11;
    #1;
    chk("reset_outs", 32'({req_ready, rsp_valid, rsp_bcd, rsp_id, rsp_err, conv_bin, busy}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 2'b00;
    req_valid_b = 2'b00;

    // Table-driven single transactions: grant, latency, result, held operand.
    for (int v = 0; v < 9; v++) begin
      req_bin   = {vecs[v].bin1, vecs[v].bin0};
      req_valid = vecs[v].valid;
      sample();
      chk("grant", 32'(req_ready), 32'(vecs[v].exp_ready));
      adv();
      req_valid = 2'b00;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 8) begin
        lat++;
        sample();
        chk("busy_active", 32'(busy), 32'd1);
        if (rsp_valid) begin
          got = 1'b1;
          chk("rsp_bcd", 32'(rsp_bcd), 32'(vecs[v].exp_bcd));
          chk("rsp_id", 32'(rsp_id), 32'(vecs[v].exp_id));
          chk("rsp_err", 32'(rsp_err), 32'(vecs[v].exp_err));
          chk("conv_bin_held", 32'(conv_bin), 32'(vecs[v].exp_conv));
          chk("rsp_latency", 32'(lat), 32'(vecs[v].exp_lat));
        end
        adv();
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout: actual=none required=response for vector %0d", v);
      end
      sample();
      chk("idle_after_rsp", 32'({busy, rsp_valid}), 32'd0);
      adv();
    end

    // Both requesters held after reset: grants alternate 0,1,0,1.
    do_reset();
    grant_log.delete();
    req_bin   = {8'd81, 8'd10};
    req_valid = 2'b11;
    for (int n = 0; n < 40 && grant_log.size() < 4; n++) begin
      sample();
      adv();
    end
    req_valid = 2'b00;
    chk("rr_grant_count", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
      chk("rr_order", 32'(grant_log[k]), 32'(k % 2));
    end
    drain();

    // Back-pressure: the response holds, no grant while busy, none in the handshake cycle.
    rsp_ready = 1'b0;
    req_bin   = {8'd5, 8'd37};
    req_valid = 2'b01;
    sample();
    chk("bp_grant", 32'(req_ready), 32'd1);
    adv();
    req_valid = 2'b11;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      sample();
      got = rsp_valid;
      adv();
    end
    chk("bp_rsp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("bp_hold", 32'({rsp_valid, rsp_bcd, rsp_id, busy, req_ready}),
          32'({1'b1, 8'h37, 2'd0, 1'b1, 2'b00}));
      adv();
    end
    rsp_ready = 1'b1;
    sample();
    chk("bp_hs_no_grant", 32'(req_ready), 32'd0);
    adv();
    sample();
    chk("bp_next_grant", 32'({rsp_valid, req_ready}), 32'({1'b0, 2'b10}));
    adv();
    req_valid = 2'b00;
    drain();

    // Reset in mid-WAIT: outputs clear at once and the transaction is dropped.
    req_bin   = {8'd0, 8'd55};
    req_valid = 2'b01;
    sample();
    chk("rst_wait_grant", 32'(req_ready), 32'd1);
    adv();
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 32'({req_ready, rsp_valid, rsp_bcd, rsp_id, rsp_err, conv_bin, busy}), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("rst_no_rsp", 32'({rsp_valid, busy}), 32'd0);
      adv();
    end
    req_bin   = {8'd0, 8'd44};
    req_valid = 2'b10;
    sample();
    chk("post_rst_grant", 32'(req_ready), 32'd2);
    adv();
    req_valid = 2'b00;
    sample();
    adv();
    sample();
    chk("post_rst_rsp", 32'({rsp_valid, rsp_bcd, rsp_id}), 32'({1'b1, 8'h00, 2'd1}));
    adv();

    // CONV_LAT=3: conv_bin is stable over T+1..T+3 and the response arrives at T+4.
    req_bin_b   = {8'd0, 8'd81};
    req_valid_b = 2'b01;
    @(negedge clk);
    chk("l3_grant", 32'(req_ready_b), 32'd1);
    adv();
    req_valid_b = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("l3_wait", 32'({conv_bin_b, rsp_valid_b, busy_b}), 32'({8'd81, 1'b0, 1'b1}));
      adv();
    end
    @(negedge clk);
    chk("l3_rsp", 32'({rsp_valid_b, rsp_bcd_b, rsp_id_b, rsp_err_b}), 32'({1'b1, 8'h81, 2'd0, 1'b0}));
    adv();
    @(negedge clk);
    chk("l3_done", 32'({rsp_valid_b, busy_b, conv_bin_b}), 32'({1'b0, 1'b0, 8'd81}));

    chk("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
